// File: rtl/mem_arb_pkg.sv
// Shared constants for the MEM-stage data RAM arbiter: FSM state encodings,
// port indices and default bus widths.
package mem_arb_pkg;

   localparam int unsigned MemArbAddrW = 3;
   localparam int unsigned MemArbDataW = 3;

   typedef logic [1:0] arb_state_t;

   localparam arb_state_t StIdle   = 2'd0;
   localparam arb_state_t StAccess = 2'd1;
   localparam arb_state_t StResp   = 2'd2;

   localparam logic Port0 = 1'b0;
   localparam logic Port1 = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational two-way picker producing a one-hot grant from the request vector.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin tie-breaking; otherwise port 0 has fixed priority.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
   input  logic       last,
`endif
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      // On a tie the port that did not win last time goes first.
      if (req[Port0] && req[Port1]) begin
         grant = last ? 2'b01 : 2'b10;
      end else begin
         grant = req;
      end
`else
      if (req[Port0]) begin
         grant[Port0] = 1'b1;
      end else begin
         grant[Port1] = req[Port1];
      end
`endif
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer for the single-ported MEM-stage data RAM (IDLE -> ACCESS -> RESP).
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin ties; default build uses fixed port-0 priority.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = MemArbAddrW,
   parameter int unsigned DATA_W = MemArbDataW
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              r0_req,
   input  logic              r0_we,
   input  logic [ADDR_W-1:0] r0_addr,
   input  logic [DATA_W-1:0] r0_wdata,
   input  logic              r1_req,
   input  logic              r1_we,
   input  logic [ADDR_W-1:0] r1_addr,
   input  logic [DATA_W-1:0] r1_wdata,
   output logic              r0_ack,
   output logic [DATA_W-1:0] r0_rdata,
   output logic              r1_ack,
   output logic [DATA_W-1:0] r1_rdata,
   output logic              mem_read_ctrl,
   output logic              mem_write_ctrl,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_data_write,
   input  logic [DATA_W-1:0] mem_data_read,
   output logic              busy
);

   arb_state_t        state_q, state_d;
   logic [1:0]        req, grant;
   logic              start, win;
   logic              win_q, we_q;
   logic              r0_ack_q, r1_ack_q;
   logic [DATA_W-1:0] r0_rdata_q, r1_rdata_q;
   logic              rd_ctrl_q, wr_ctrl_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              busy_q;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   assign req = {r1_req, r0_req};

`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic last_q;

   mem_arb_pick u_pick (
      .req   (req),
      .last  (last_q),
      .grant (grant)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= Port1;
      end else if (state_q == StIdle && start) begin
         last_q <= win;
      end
   end
`else
   mem_arb_pick u_pick (
      .req   (req),
      .grant (grant)
   );
`endif

   assign start = |grant;
   assign win   = grant[Port1];

   always_comb begin
      sel_we    = win ? r1_we    : r0_we;
      sel_addr  = win ? r1_addr  : r0_addr;
      sel_wdata = win ? r1_wdata : r0_wdata;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (start) state_d = StAccess;
         StAccess: state_d = StResp;
         StResp:   state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         win_q      <= Port0;
         we_q       <= 1'b0;
         r0_ack_q   <= 1'b0;
         r1_ack_q   <= 1'b0;
         r0_rdata_q <= '0;
         r1_rdata_q <= '0;
         rd_ctrl_q  <= 1'b0;
         wr_ctrl_q  <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= (state_d != StIdle);
         unique case (state_q)
            StIdle: begin
               // Only the winner's command is captured; the loser is sampled again later.
               if (start) begin
                  win_q     <= win;
                  we_q      <= sel_we;
                  addr_q    <= sel_addr;
                  wdata_q   <= sel_wdata;
                  rd_ctrl_q <= !sel_we;
                  wr_ctrl_q <= sel_we;
               end
            end
            StAccess: begin
               rd_ctrl_q <= 1'b0;
               wr_ctrl_q <= 1'b0;
               if (win_q == Port0) begin
                  r0_ack_q <= 1'b1;
                  if (!we_q) r0_rdata_q <= mem_data_read;
               end else begin
                  r1_ack_q <= 1'b1;
                  if (!we_q) r1_rdata_q <= mem_data_read;
               end
            end
            StResp: begin
               r0_ack_q <= 1'b0;
               r1_ack_q <= 1'b0;
            end
            default: begin
               rd_ctrl_q <= 1'b0;
               wr_ctrl_q <= 1'b0;
               r0_ack_q  <= 1'b0;
               r1_ack_q  <= 1'b0;
            end
         endcase
      end
   end

   assign r0_ack         = r0_ack_q;
   assign r1_ack         = r1_ack_q;
   assign r0_rdata       = r0_rdata_q;
   assign r1_rdata       = r1_rdata_q;
   assign mem_read_ctrl  = rd_ctrl_q;
   assign mem_write_ctrl = wr_ctrl_q;
   assign mem_address    = addr_q;
   assign mem_data_write = wdata_q;
   assign busy           = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a negedge-sampling RAM model; expectations track
// MEM_ARB_ROUND_ROBIN_EN so the same bench covers both builds.
module tb_mem_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       r0_req = 1'b0, r0_we = 1'b0, r1_req = 1'b0, r1_we = 1'b0;
   logic [2:0] r0_addr = '0, r0_wdata = '0, r1_addr = '0, r1_wdata = '0;
   logic       r0_ack, r1_ack, mem_read_ctrl, mem_write_ctrl, busy;
   logic [2:0] r0_rdata, r1_rdata, mem_address, mem_data_write;
   logic [2:0] mem_data_read = '0;
   logic [2:0] ram [8];

   int n_vec = 0;
   int n_err = 0;

   mem_arbiter dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .r0_req         (r0_req),
      .r0_we          (r0_we),
      .r0_addr        (r0_addr),
      .r0_wdata       (r0_wdata),
      .r1_req         (r1_req),
      .r1_we          (r1_we),
      .r1_addr        (r1_addr),
      .r1_wdata       (r1_wdata),
      .r0_ack         (r0_ack),
      .r0_rdata       (r0_rdata),
      .r1_ack         (r1_ack),
      .r1_rdata       (r1_rdata),
      .mem_read_ctrl  (mem_read_ctrl),
      .mem_write_ctrl (mem_write_ctrl),
      .mem_address    (mem_address),
      .mem_data_write (mem_data_write),
      .mem_data_read  (mem_data_read),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   // RAM acts on the falling edge inside the ACCESS cycle.
   always @(negedge clk) begin
      if (mem_write_ctrl) ram[mem_address] <= mem_data_write;
      if (mem_read_ctrl) mem_data_read <= ram[mem_address];
   end

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         n_vec++;
         if (mem_read_ctrl && mem_write_ctrl) begin
            n_err++;
            $display("FAIL ctrl_mutex at %0t: read_ctrl=%b write_ctrl=%b, required not both 1",
                     $time, mem_read_ctrl, mem_write_ctrl);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   typedef struct {
      logic q0; logic w0; logic [2:0] a0; logic [2:0] d0;
      logic q1; logic w1; logic [2:0] a1; logic [2:0] d1;
      logic e_rd; logic e_wr; logic [2:0] e_addr; logic [2:0] e_wd;
      logic e_ack0; logic e_ack1; logic [2:0] e_r0; logic [2:0] e_r1;
   } vec_t;

   vec_t tbl [8];

   initial begin
      int n_rd, n_ack0, n_ack1, reqs;
      logic drop_next, raise_next, rr, e0, e1;

      ram[0] = 3'd1; ram[1] = 3'd2; ram[2] = 3'd6; ram[3] = 3'd4;
      ram[4] = 3'd7; ram[5] = 3'd0; ram[6] = 3'd5; ram[7] = 3'd3;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr = 1'b1;
`else
      rr = 1'b0;
`endif

      //          q0    w0    a0    d0    q1    w1    a1    d1    rd    wr   addr   wd   ack0  ack1   r0    r1
      tbl[0] = '{1'b1, 1'b1, 3'd5, 3'd3, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1, 3'd5, 3'd3, 1'b1, 1'b0, 3'd0, 3'd0};
      tbl[1] = '{1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 3'd5, 3'd0, 1'b1, 1'b0, 3'd5, 3'd0, 1'b0, 1'b1, 3'd0, 3'd3};
      tbl[2] = '{1'b1, 1'b0, 3'd2, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 3'd2, 3'd0, 1'b1, 1'b0, 3'd6, 3'd3};
      tbl[3] = '{1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b1, 3'd2, 3'd1, 1'b0, 1'b1, 3'd2, 3'd1, 1'b0, 1'b1, 3'd6, 3'd3};
      tbl[4] = '{1'b1, 1'b0, 3'd2, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 3'd2, 3'd0, 1'b1, 1'b0, 3'd1, 3'd3};
`ifdef MEM_ARB_ROUND_ROBIN_EN
      tbl[5] = '{1'b1, 1'b1, 3'd7, 3'd5, 1'b1, 1'b0, 3'd0, 3'd2, 1'b1, 1'b0, 3'd0, 3'd2, 1'b0, 1'b1, 3'd1, 3'd1};
      tbl[6] = '{1'b1, 1'b0, 3'd7, 3'd0, 1'b1, 1'b0, 3'd6, 3'd0, 1'b1, 1'b0, 3'd7, 3'd0, 1'b1, 1'b0, 3'd3, 3'd1};
      tbl[7] = '{1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 3'd7, 3'd4, 1'b1, 1'b0, 3'd7, 3'd4, 1'b0, 1'b1, 3'd3, 3'd3};
`else
      tbl[5] = '{1'b1, 1'b1, 3'd7, 3'd5, 1'b1, 1'b0, 3'd0, 3'd2, 1'b0, 1'b1, 3'd7, 3'd5, 1'b1, 1'b0, 3'd1, 3'd3};
      tbl[6] = '{1'b1, 1'b0, 3'd7, 3'd0, 1'b1, 1'b0, 3'd6, 3'd0, 1'b1, 1'b0, 3'd7, 3'd0, 1'b1, 1'b0, 3'd5, 3'd3};
      tbl[7] = '{1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 3'd7, 3'd4, 1'b1, 1'b0, 3'd7, 3'd4, 1'b0, 1'b1, 3'd5, 3'd5};
`endif

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ack0", 32'(r0_ack), 0);
      chk("rst_ack1", 32'(r1_ack), 0);
      chk("rst_rd", 32'(mem_read_ctrl), 0);
      chk("rst_wr", 32'(mem_write_ctrl), 0);
      chk("rst_addr", 32'(mem_address), 0);
      chk("rst_wd", 32'(mem_data_write), 0);
      chk("rst_r0data", 32'(r0_rdata), 0);
      chk("rst_r1data", 32'(r1_rdata), 0);

      // Reset while an r0 write is in ACCESS: abandon it, no ack, RAM untouched.
      @(negedge clk);
      rst_n = 1'b1;
      r0_req = 1'b1; r0_we = 1'b1; r0_addr = 3'd4; r0_wdata = 3'd2;
      @(posedge clk);
      #1;
      chk("midrst_wr_before", 32'(mem_write_ctrl), 1);
      chk("midrst_busy_before", 32'(busy), 1);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_wr", 32'(mem_write_ctrl), 0);
      chk("midrst_rd", 32'(mem_read_ctrl), 0);
      chk("midrst_busy", 32'(busy), 0);
      r0_req = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1 chk("midrst_no_ack0", 32'(r0_ack), 0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      chk("midrst_ram_kept", 32'(ram[4]), 7);

      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         r0_req = tbl[i].q0; r0_we = tbl[i].w0; r0_addr = tbl[i].a0; r0_wdata = tbl[i].d0;
         r1_req = tbl[i].q1; r1_we = tbl[i].w1; r1_addr = tbl[i].a1; r1_wdata = tbl[i].d1;
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_rd", i), 32'(mem_read_ctrl), 32'(tbl[i].e_rd));
         chk($sformatf("v%0d_wr", i), 32'(mem_write_ctrl), 32'(tbl[i].e_wr));
         chk($sformatf("v%0d_addr", i), 32'(mem_address), 32'(tbl[i].e_addr));
         chk($sformatf("v%0d_wd", i), 32'(mem_data_write), 32'(tbl[i].e_wd));
         chk($sformatf("v%0d_busy", i), 32'(busy), 1);
         chk($sformatf("v%0d_early_ack", i), 32'({r1_ack, r0_ack}), 0);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_ack0", i), 32'(r0_ack), 32'(tbl[i].e_ack0));
         chk($sformatf("v%0d_ack1", i), 32'(r1_ack), 32'(tbl[i].e_ack1));
         chk($sformatf("v%0d_ctrl_off", i), 32'({mem_read_ctrl, mem_write_ctrl}), 0);
         chk($sformatf("v%0d_r0data", i), 32'(r0_rdata), 32'(tbl[i].e_r0));
         chk($sformatf("v%0d_r1data", i), 32'(r1_rdata), 32'(tbl[i].e_r1));
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_ack_drop", i), 32'({r1_ack, r0_ack}), 0);
         chk($sformatf("v%0d_idle", i), 32'(busy), 0);
         r0_req = 1'b0; r1_req = 1'b0;
      end

      // Both ports requesting continuously from reset.
      @(negedge clk);
      rst_n = 1'b0;
      r0_req = 1'b1; r0_we = 1'b0; r0_addr = 3'd1;
      r1_req = 1'b1; r1_we = 1'b0; r1_addr = 3'd3;
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk);
         #1;
         e0 = (c % 3 == 1) && (!rr || (c % 6 == 1));
         e1 = rr && (c % 6 == 4);
         chk($sformatf("tie_c%0d_ack0", c), 32'(r0_ack), 32'(e0));
         chk($sformatf("tie_c%0d_ack1", c), 32'(r1_ack), 32'(e1));
         if (e0) chk($sformatf("tie_c%0d_r0data", c), 32'(r0_rdata), 2);
         if (e1) chk($sformatf("tie_c%0d_r1data", c), 32'(r1_rdata), 4);
      end
      r0_req = 1'b0; r1_req = 1'b0;

      // r0 drops req at the ack edge and re-raises one cycle later.
      repeat (2) @(negedge clk);
      r0_req = 1'b1; r0_we = 1'b0; r0_addr = 3'd1;
      n_rd = 0; n_ack0 = 0; n_ack1 = 0; reqs = 1;
      drop_next = 1'b0; raise_next = 1'b0;
      for (int c = 0; c < 14; c++) begin
         @(posedge clk);
         #1;
         if (drop_next) begin
            r0_req = 1'b0;
            drop_next = 1'b0;
            raise_next = (reqs < 2);
         end else if (raise_next) begin
            r0_req = 1'b1;
            reqs++;
            raise_next = 1'b0;
         end
         if (mem_read_ctrl) n_rd++;
         if (r1_ack) n_ack1++;
         if (r0_ack) begin
            n_ack0++;
            drop_next = 1'b1;
         end
      end
      chk("rereq_rd_pulses", 32'(n_rd), 2);
      chk("rereq_ack0", 32'(n_ack0), 2);
      chk("rereq_ack1", 32'(n_ack1), 0);
      chk("rereq_idle", 32'(busy), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
